// File: rtl/capsense_tx_scan_pkg.sv
// Shared definitions for the mutual-cap TX scanner and the receiver's
// button-decision logic: scan state encodings and default datapath widths.
package capsense_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DISCH  = 2'd1;
   localparam logic [1:0] CHARGE = 2'd2;
   localparam logic [1:0] REPORT = 2'd3;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_CH_W  = 2;

endpackage

// File: rtl/capsense_tx_scan_if.sv
// Sample tick, start, sense pin and electrode drive / result bundle of the TX scanner.
interface capsense_tx_scan_if
   import capsense_pkg::*;
#(
   parameter int N_TX  = 4,
   parameter int CNT_W = DEF_CNT_W,
   parameter int CH_W  = DEF_CH_W
);

   logic             ena_i;
   logic             start_i;
   logic             rx_i;
   logic [N_TX-1:0]  tx_o;
   logic [N_TX-1:0]  tx_oe_o;
   logic             rx_dis_o;
   logic             busy_o;
   logic             done_o;
   logic [CH_W-1:0]  chan_o;
   logic [CNT_W-1:0] count_o;
   logic             timeout_o;

   modport master (
      output ena_i, start_i, rx_i,
      input  tx_o, tx_oe_o, rx_dis_o, busy_o, done_o, chan_o, count_o, timeout_o
   );

   modport slave (
      input  ena_i, start_i, rx_i,
      output tx_o, tx_oe_o, rx_dis_o, busy_o, done_o, chan_o, count_o, timeout_o
   );

endinterface

// File: rtl/capsense_tx_scan_sync2.sv
// Two-flop synchronizer for asynchronous sense-pin inputs; clears to 0 on reset.
module capsense_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/capsense_tx_scan.sv
// Mutual-capacitance TX scanner: per electrode, discharge, drive TX high and
// count sample ticks until the shared RX comparator trips (or times out).
module capsense_tx_scan
   import capsense_pkg::*;
#(
   parameter int N_TX       = 4,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DISCH_CYC  = 16,
   parameter int CHARGE_MAX = 255,
   parameter int CH_W       = DEF_CH_W
) (
   input logic               clk_i,
   input logic               rst_i,
   capsense_tx_scan_if.slave bus
);

   localparam logic [CNT_W-1:0] DISCH_LAST = CNT_W'(DISCH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(CHARGE_MAX);
   localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_TX - 1);

   logic             rx_s;
   logic [1:0]       state_q;
   logic [CH_W-1:0]  ch_q;
   logic [CNT_W-1:0] tcnt_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N_TX-1:0]  tx_q;
   logic [N_TX-1:0]  tx_oe_q;
   logic             rx_dis_q;
   logic             busy_q;
   logic             done_q;
   logic [CH_W-1:0]  chan_q;
   logic [CNT_W-1:0] count_q;
   logic             timeout_q;
   logic [N_TX-1:0]  ch_onehot;

   capsense_sync2 u_rx_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (bus.rx_i),
      .q_o   (rx_s)
   );

   assign ch_onehot = N_TX'(1) << ch_q;

   // Pin-level outputs are loaded on the same edge as the state change,
   // so each transition also sets the drive pattern of the state it enters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         tcnt_q    <= '0;
         cnt_q     <= '0;
         tx_q      <= '0;
         tx_oe_q   <= '1;
         rx_dis_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         chan_q    <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         tx_oe_q <= '1;
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  state_q  <= DISCH;
                  ch_q     <= '0;
                  tcnt_q   <= '0;
                  busy_q   <= 1'b1;
                  tx_q     <= '0;
                  rx_dis_q <= 1'b1;
               end
            end
            DISCH: begin
               if (bus.ena_i) begin
                  if (tcnt_q == DISCH_LAST) begin
                     state_q  <= CHARGE;
                     cnt_q    <= '0;
                     tcnt_q   <= '0;
                     tx_q     <= ch_onehot;
                     rx_dis_q <= 1'b0;
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
            end
            CHARGE: begin
               // A comparator trip outranks the timeout on the same tick.
               if (bus.ena_i) begin
                  if (rx_s || (cnt_q == CNT_LIMIT)) begin
                     state_q   <= REPORT;
                     done_q    <= 1'b1;
                     chan_q    <= ch_q;
                     count_q   <= rx_s ? cnt_q : CNT_LIMIT;
                     timeout_q <= ~rx_s;
                     tx_q      <= '0;
                     rx_dis_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            REPORT: begin
               if (ch_q == CH_LAST) begin
                  state_q <= IDLE;
                  ch_q    <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= DISCH;
                  ch_q    <= ch_q + 1'b1;
                  tcnt_q  <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx_o      = tx_q;
   assign bus.tx_oe_o   = tx_oe_q;
   assign bus.rx_dis_o  = rx_dis_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.chan_o    = chan_q;
   assign bus.count_o   = count_q;
   assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_capsense_tx_scan.sv
// Directed bench for capsense_tx_scan: N_TX=4, DISCH_CYC=4, CHARGE_MAX=10, ena every 4 clk.
module tb_capsense_tx_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   capsense_tx_scan_if #(.N_TX(4), .CNT_W(8), .CH_W(2)) bus ();

   capsense_tx_scan #(
      .N_TX       (4),
      .CNT_W      (8),
      .DISCH_CYC  (4),
      .CHARGE_MAX (10),
      .CH_W       (2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   int n_done, idle_clks, r_gap;
   int r_chan [8];
   int r_count[8];
   int r_to   [8];
   logic [3:0] r_tx[8];
   bit r_hang;
   logic r_post_busy, r_post_dis, r_post_done;
   logic [3:0] r_post_tx;
   logic [3:0] s_tx, s_oe;
   logic s_dis, s_busy, s_done, s_to;
   logic [7:0] s_count;
   logic [1:0] s_chan;
   logic end_busy;

   // Drives one scan; ena every 4 clk, rx_i rises after rise_after CHARGE ticks
   // (0 = held high, large = never). Optional start poke / reset during a channel.
   task automatic run_scan(input int rise_after, input bit hold_start, input int n_target,
                           input int poke_ch, input int rst_ch);
      int phase, chg_ticks, rst_wait;
      bit prev_chg, did_rst, post_pending, finished;
      logic [3:0] poke_one, rst_one;
      poke_one = (poke_ch >= 0) ? (4'b0001 << poke_ch) : 4'b0000;
      rst_one  = (rst_ch  >= 0) ? (4'b0001 << rst_ch)  : 4'b0000;
      n_done = 0; idle_clks = 0; r_gap = 0; r_hang = 0;
      phase = 0; chg_ticks = 0; rst_wait = 0;
      prev_chg = 0; did_rst = 0; post_pending = 0; finished = 0;
      for (int i = 0; i < 8; i++) r_tx[i] = 4'h0;
      bus.rx_i    = (rise_after == 0);
      bus.start_i = 1'b1;
      bus.ena_i   = 1'b0;
      for (int cyc = 0; cyc < 1500 && !finished; cyc++) begin
         @(posedge clk); #1;
         if (post_pending) begin
            r_post_busy = bus.busy_o; r_post_tx = bus.tx_o;
            r_post_dis  = bus.rx_dis_o; r_post_done = bus.done_o;
            post_pending = 0;
         end
         if (bus.done_o) begin
            if (n_done < 8) begin
               r_chan[n_done] = bus.chan_o; r_count[n_done] = bus.count_o;
               r_to[n_done] = bus.timeout_o;
            end
            if (n_done == 0) post_pending = 1;
            n_done++;
            r_gap = 0;
         end else begin
            r_gap++;
         end
         if (n_done >= 1 && !bus.busy_o) idle_clks++;
         if (prev_chg && bus.ena_i) chg_ticks++;
         if (bus.tx_o != 4'h0) begin
            if (!prev_chg && n_done < 8) r_tx[n_done] = bus.tx_o;
            prev_chg = 1;
            if (rise_after > 0 && chg_ticks >= rise_after) bus.rx_i = 1'b1;
         end else begin
            prev_chg = 0;
            chg_ticks = 0;
            if (rise_after > 0) bus.rx_i = 1'b0;
         end
         bus.start_i = hold_start || (poke_ch >= 0 && bus.tx_o == poke_one && chg_ticks == 2);
         if (did_rst) begin
            rst_wait++;
            if (rst_wait == 2) rst = 1'b0;
            if (rst_wait >= 40) finished = 1;
         end else if (rst_ch >= 0 && bus.tx_o == rst_one && chg_ticks == 2) begin
            bus.start_i = 1'b0;
            #2 rst = 1'b1;
            #1;
            s_tx = bus.tx_o; s_oe = bus.tx_oe_o; s_dis = bus.rx_dis_o; s_busy = bus.busy_o;
            s_done = bus.done_o; s_count = bus.count_o; s_chan = bus.chan_o; s_to = bus.timeout_o;
            did_rst = 1;
         end
         if (!did_rst && n_done >= n_target && (hold_start || !bus.busy_o)) finished = 1;
         phase = (phase + 1) % 4;
         bus.ena_i = (phase == 0);
      end
      bus.start_i = 1'b0;
      bus.ena_i   = 1'b0;
      end_busy    = bus.busy_o;
      if (!finished) r_hang = 1;
   endtask

   task automatic test_reset();
      logic [3:0] exp_oe;
      exp_oe = 4'hF;
      bus.ena_i = 1'b0; bus.start_i = 1'b0; bus.rx_i = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (bus.tx_oe_o !== exp_oe) begin n_err++; $display("FAIL reset_oe got %h want F", bus.tx_oe_o); end
      n_vec++; if (bus.tx_o !== 4'h0) begin n_err++; $display("FAIL reset_tx got %h want 0", bus.tx_o); end
      n_vec++; if (bus.rx_dis_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         n_err++; $display("FAIL reset_ctl got dis=%b busy=%b done=%b want 1/0/0", bus.rx_dis_o, bus.busy_o, bus.done_o); end
      n_vec++; if (bus.count_o !== 8'd0 || bus.chan_o !== 2'd0 || bus.timeout_o !== 1'b0) begin
         n_err++; $display("FAIL reset_result got cnt=%0d ch=%0d to=%b want 0", bus.count_o, bus.chan_o, bus.timeout_o); end
      bus.start_i = 1'b1;
      @(posedge clk); #1 bus.start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL start_busy got %b want 1", bus.busy_o); end
      #3 rst = 1'b1;
      #1;
      n_vec++; if (bus.busy_o !== 1'b0 || bus.tx_oe_o !== exp_oe || bus.rx_dis_o !== 1'b1) begin
         n_err++; $display("FAIL async_reset got busy=%b oe=%h dis=%b want 0/F/1", bus.busy_o, bus.tx_oe_o, bus.rx_dis_o); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_nominal();
      logic [3:0] exp_tx;
      run_scan(5, 1'b0, 4, -1, -1);
      n_vec++; if (r_hang || n_done !== 4) begin n_err++; $display("FAIL nom_ndone got %0d hang=%0d want 4", n_done, r_hang); end
      for (int i = 0; i < 4; i++) begin
         exp_tx = 4'b0001 << i;
         n_vec++; if (r_chan[i] !== i) begin n_err++; $display("FAIL nom_chan[%0d] got %0d want %0d", i, r_chan[i], i); end
         n_vec++; if (r_count[i] !== 5 || r_to[i] !== 0) begin
            n_err++; $display("FAIL nom_count[%0d] got %0d to=%0d want 5 to=0", i, r_count[i], r_to[i]); end
         n_vec++; if (r_tx[i] !== exp_tx) begin n_err++; $display("FAIL nom_tx[%0d] got %h want %h", i, r_tx[i], exp_tx); end
      end
      n_vec++; if (r_gap !== 1 || end_busy !== 1'b0) begin
         n_err++; $display("FAIL nom_busy_end got gap=%0d busy=%b want 1/0", r_gap, end_busy); end
   endtask

   task automatic test_timeout();
      run_scan(1000, 1'b0, 4, -1, -1);
      n_vec++; if (r_hang || n_done !== 4) begin n_err++; $display("FAIL to_ndone got %0d want 4", n_done); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (r_count[i] !== 10 || r_to[i] !== 1 || r_chan[i] !== i) begin
            n_err++; $display("FAIL to_result[%0d] got cnt=%0d to=%0d ch=%0d want 10/1/%0d", i, r_count[i], r_to[i], r_chan[i], i); end
      end
      n_vec++; if (r_post_busy !== 1'b1 || r_post_tx !== 4'h0 || r_post_dis !== 1'b1 || r_post_done !== 1'b0) begin
         n_err++; $display("FAIL to_next_disch got busy=%b tx=%h dis=%b done=%b want 1/0/1/0",
                           r_post_busy, r_post_tx, r_post_dis, r_post_done); end
   endtask

   task automatic test_simultaneous();
      run_scan(10, 1'b0, 4, -1, -1);
      n_vec++; if (r_hang || n_done !== 4) begin n_err++; $display("FAIL sim_ndone got %0d want 4", n_done); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (r_count[i] !== 10 || r_to[i] !== 0) begin
            n_err++; $display("FAIL sim_result[%0d] got cnt=%0d to=%0d want 10/0", i, r_count[i], r_to[i]); end
      end
   endtask

   task automatic test_immediate();
      run_scan(0, 1'b0, 4, -1, -1);
      n_vec++; if (r_hang || n_done !== 4) begin n_err++; $display("FAIL imm_ndone got %0d want 4", n_done); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (r_count[i] !== 0 || r_to[i] !== 0 || r_chan[i] !== i) begin
            n_err++; $display("FAIL imm_result[%0d] got cnt=%0d to=%0d ch=%0d want 0/0/%0d", i, r_count[i], r_to[i], r_chan[i], i); end
      end
      bus.rx_i = 1'b0;
   endtask

   task automatic test_start_ignored();
      int extra;
      run_scan(5, 1'b0, 4, 1, -1);
      n_vec++; if (r_hang || n_done !== 4) begin n_err++; $display("FAIL poke_ndone got %0d want 4", n_done); end
      n_vec++; if (r_chan[3] !== 3 || r_count[1] !== 5) begin
         n_err++; $display("FAIL poke_result got ch3=%0d cnt1=%0d want 3/5", r_chan[3], r_count[1]); end
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.done_o || bus.busy_o) extra++;
      end
      n_vec++; if (extra !== 0) begin n_err++; $display("FAIL poke_queued got %0d active clk want 0", extra); end
   endtask

   task automatic test_reset_mid_scan();
      run_scan(5, 1'b0, 4, -1, 2);
      n_vec++; if (r_hang || n_done !== 2) begin n_err++; $display("FAIL rst_ndone got %0d want 2", n_done); end
      n_vec++; if (s_busy !== 1'b0 || s_tx !== 4'h0 || s_oe !== 4'hF || s_dis !== 1'b1 || s_done !== 1'b0) begin
         n_err++; $display("FAIL rst_outputs got busy=%b tx=%h oe=%h dis=%b done=%b want 0/0/F/1/0",
                           s_busy, s_tx, s_oe, s_dis, s_done); end
      n_vec++; if (s_count !== 8'd0 || s_chan !== 2'd0 || s_to !== 1'b0) begin
         n_err++; $display("FAIL rst_result got cnt=%0d ch=%0d to=%b want 0", s_count, s_chan, s_to); end
      n_vec++; if (end_busy !== 1'b0) begin n_err++; $display("FAIL rst_idle got busy=%b want 0", end_busy); end
      run_scan(5, 1'b0, 4, -1, -1);
      n_vec++; if (r_hang || n_done !== 4 || r_chan[0] !== 0 || r_count[0] !== 5) begin
         n_err++; $display("FAIL rst_restart got n=%0d ch0=%0d cnt0=%0d want 4/0/5", n_done, r_chan[0], r_count[0]); end
   endtask

   task automatic test_back_to_back();
      run_scan(0, 1'b1, 5, -1, -1);
      n_vec++; if (r_hang || n_done !== 5) begin n_err++; $display("FAIL b2b_ndone got %0d want 5", n_done); end
      n_vec++; if (idle_clks !== 1) begin n_err++; $display("FAIL b2b_idle got %0d want 1", idle_clks); end
      n_vec++; if (r_chan[4] !== 0 || r_chan[3] !== 3 || r_count[4] !== 0) begin
         n_err++; $display("FAIL b2b_wrap got ch3=%0d ch4=%0d cnt4=%0d want 3/0/0", r_chan[3], r_chan[4], r_count[4]); end
   endtask

   initial begin
      bus.ena_i = 1'b0; bus.start_i = 1'b0; bus.rx_i = 1'b0;
      test_reset();
      test_nominal();
      test_timeout();
      test_simultaneous();
      test_immediate();
      test_start_ignored();
      test_reset_mid_scan();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/capsense_tx_scan.md
Name: capsense_tx_scan

Overview:
- Transmit/excitation side of mutual-capacitance sensing; complements the self-cap CapSense receiver.
- Scans N_TX transmit electrodes round-robin. Per electrode:
  - discharge everything;
  - drive that TX electrode high;
  - count ena_i ticks until the shared RX sense comparator input goes high.
- Reports one result per electrode through a done pulse. Sits between the sample-rate divider (ena_i) and the button-decision logic.

Parameters:
- N_TX, 4, number of TX electrodes (1..16).
- CNT_W, 8, width of the charge-time counter.
- DISCH_CYC, 16, ena_i ticks spent in discharge per electrode (1..2^CNT_W).
- CHARGE_MAX, 255, timeout count (must be < 2^CNT_W).
- CH_W, 2, width of the channel index; must satisfy 2^CH_W >= N_TX.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- ena_i  in  1  sample-rate tick, 1 clk wide.
- start_i  in  1  start one full scan; honoured only in IDLE.
- rx_i  in  1  raw RX sense pin level, asynchronous to clk_i.
- tx_o  out  N_TX  TX electrode drive levels.
- tx_oe_o  out  N_TX  TX output enables.
- rx_dis_o  out  1  RX discharge enable: drive RX pin low when 1.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-clk pulse, result valid.
- chan_o  out  CH_W  electrode index of the last result.
- count_o  out  CNT_W  charge ticks of the last result.
- timeout_o  out  1  last result hit CHARGE_MAX.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-high; all flops clear immediately on rst_i.
- rx_i synchronisation:
  - rx_i passes through a 2-FF synchronizer; rx_s is the synchronised value, 2 clk latency.
  - Synchronizer flops reset to 0.
- Reset values:
  - state=IDLE, tx_o=0, tx_oe_o=all 1, rx_dis_o=1.
  - busy_o=0, done_o=0, chan_o=0, count_o=0, timeout_o=0.
  - Internal ch=0, tcnt=0, cnt=0.
- Outputs: tx_o, tx_oe_o, rx_dis_o and busy_o are registered; they change on the same edge as the state transition.
- IDLE:
  - TX all driven low; RX discharged; busy_o=0.
  - start_i=1 -> DISCH with ch=0, tcnt=0.
- DISCH:
  - TX all driven low; rx_dis_o=1; busy_o=1.
  - On each ena_i: if tcnt==DISCH_CYC-1 -> CHARGE with cnt=0, tcnt=0; else tcnt++.
- CHARGE:
  - tx_o = one-hot(ch); tx_oe_o all 1; rx_dis_o=0; busy_o=1.
  - Only ena_i cycles are evaluated. In priority order:
    1. rx_s=1 -> REPORT; latch count_o=cnt, timeout_o=0.
    2. Else if cnt==CHARGE_MAX -> REPORT; latch count_o=CHARGE_MAX, timeout_o=1.
    3. Else cnt++.
  - Simultaneous rx_s=1 and cnt==CHARGE_MAX: the rx_s branch wins, so timeout_o=0.
  - rx_s=1 on the first ena_i of CHARGE gives count_o=0.
- REPORT (exactly 1 clk):
  - done_o=1; chan_o=ch.
  - TX all driven low and RX discharged.
  - If ch==N_TX-1 -> IDLE with ch=0; else ch++ -> DISCH with tcnt=0.
- Result holding: count_o, chan_o and timeout_o hold until the next REPORT.
- ena_i outside DISCH/CHARGE has no effect.
- start_i while busy_o=1 is ignored; no queueing.
- start_i held high continuously: a new scan starts on the first clk in IDLE, giving back-to-back scans with 1 idle clk between them.
- Reset mid-scan: immediate return to reset values; the partial result is discarded and no done_o is issued.
- Counter rules:
  - cnt never exceeds CHARGE_MAX.
  - tcnt never exceeds DISCH_CYC-1.
  - ch never exceeds N_TX-1; no wrap beyond the last electrode.

Decomposition:
- Package capsense_pkg:
  - state encoding localparams IDLE=0, DISCH=1, CHARGE=2, REPORT=3 (2 bits);
  - default widths CNT_W and CH_W.
  - Shared with the receiver's button-decision logic.
- Sub-module capsense_sync2: 2-FF synchronizer, async active-high reset to 0. Reused for any sense-pin input.
- FSM, counters and output registers stay in capsense_tx_scan.

Test Plan:
- Reset/idle: assert rst_i mid-clock.
  - Expect all outputs at reset values immediately: tx_oe_o=4'hF, tx_o=0, rx_dis_o=1, busy_o=0.
- Nominal scan: N_TX=4, DISCH_CYC=4, ena_i every 4 clk, rx_i rises 5 ena ticks after each CHARGE entry.
  - Expect 4 done_o pulses, chan_o=0,1,2,3, count_o=5 each (± synchronizer alignment, checked exactly against the model).
  - tx_o one-hot 1,2,4,8 during each CHARGE.
  - busy_o=0 after the last pulse.
- Timeout: CHARGE_MAX=10, rx_i held 0.
  - Expect each result count_o=10, timeout_o=1.
  - The next channel starts DISCH right after the REPORT clk.
- Simultaneity: rx_s rises on the same ena_i where cnt==CHARGE_MAX.
  - Expect count_o=CHARGE_MAX, timeout_o=0.
- Immediate charge: rx_i=1 throughout.
  - Expect count_o=0 for all channels, timeout_o=0.
- Control robustness:
  - start_i pulsed during CHARGE of ch1 -> ignored; exactly 4 results.
  - rst_i asserted during ch2 CHARGE -> no done_o for ch2; busy_o=0.
  - Next start_i restarts from chan 0.
